// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit, buffers
// in-order responses with their PCs, and flushes everything on a branch redirect.
module fetch_prefetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [WIDTH-1:0]           imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [WIDTH-1:0]           imem_rsp_data,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [WIDTH-1:0]           if_instr,
  output logic [WIDTH-1:0]           if_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] fetch_pc_reg;
  logic [WIDTH-1:0] rsp_pc_reg;
  logic [CW-1:0]    inflight_reg;
  logic [CW-1:0]    discard_reg;
  logic [CW-1:0]    count_reg;
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic [CW:0]      credits_used;
  logic [WIDTH-1:0] redirect_target;
  logic             req_fire;
  logic             rsp_take;
  logic             push;
  logic             pop;

  // Credits held = buffered entries plus fetches whose data will actually be kept.
  assign credits_used    = {1'b0, count_reg} + {1'b0, inflight_reg} - {1'b0, discard_reg};
  assign redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};

  assign imem_req_valid = !reset && !redirect_valid && (credits_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take = imem_rsp_valid && (inflight_reg != '0);
  assign push     = rsp_take && (discard_reg == '0) && !redirect_valid;
  assign pop      = if_valid && if_ready && !redirect_valid;

  assign if_valid = (count_reg != '0);
  assign q_count  = count_reg;
  assign if_instr = instr_mem[head_reg];
  assign if_pc    = pc_mem[head_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= imem_rsp_data;
      pc_mem[tail_reg]    <= rsp_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      discard_reg  <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else if (redirect_valid) begin
      // Every fetch still outstanding after this cycle belongs to the old path.
      fetch_pc_reg <= redirect_target;
      rsp_pc_reg   <= redirect_target;
      inflight_reg <= inflight_reg - CW'(rsp_take);
      discard_reg  <= inflight_reg - CW'(rsp_take);
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + WIDTH'(4);
      end
      if (push) begin
        rsp_pc_reg <= rsp_pc_reg + WIDTH'(4);
        tail_reg   <= tail_reg + PW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PW'(1);
      end
      if (rsp_take && (discard_reg != '0)) begin
        discard_reg <= discard_reg - CW'(1);
      end
      inflight_reg <= inflight_reg + CW'(req_fire) - CW'(rsp_take);
      count_reg    <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: a queue-based model of fetches and
// buffered instructions predicts every output each cycle; an in-bench memory answers fetches.
module tb_fetch_prefetch_queue;

  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .q_count(q_count)
  );

  // An outstanding fetch: its address, whether its data is still wanted, and when memory answers.
  typedef struct {
    logic [31:0] addr;
    bit          keep;
    int          due;
  } fetch_t;

  fetch_t      pend[$];
  logic [31:0] exq[$];
  logic [31:0] m_fetch_pc;
  int          last_due;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic run_cycle(input bit rst, input bit rdr, input logic [31:0] rdr_pc,
                           input bit rq_rdy, input bit ifr, input int lat);
    bit     exp_rv;
    bit     fire;
    bit     rsp;
    bit     kept;
    int     kept_n;
    int     due;
    fetch_t f;

    rsp = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
    reset          = rst;
    redirect_valid = rdr;
    redirect_pc    = rdr_pc;
    imem_req_ready = rq_rdy;
    if_ready       = ifr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
    #2;

    kept_n = 0;
    foreach (pend[i]) if (pend[i].keep) kept_n++;
    exp_rv = !rst && !rdr && ((exq.size() + kept_n) < DEPTH);
    check_val("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check_val("req_addr", imem_req_addr, m_fetch_pc);
    check_val("q_count", 32'(q_count), 32'(exq.size()));
    check_val("if_valid", 32'(if_valid), 32'(exq.size() != 0));
    if (exq.size() != 0) begin
      check_val("if_pc", if_pc, exq[0]);
      check_val("if_instr", if_instr, mem_word(exq[0]));
    end

    if (rst) begin
      pend.delete();
      exq.delete();
      m_fetch_pc = RESET_PC;
      last_due   = cyc;
    end else begin
      fire = exp_rv && rq_rdy;
      kept = 1'b0;
      if (rsp) begin
        f    = pend.pop_front();
        kept = f.keep && !rdr;
      end
      if (!rdr && ifr && (exq.size() != 0)) begin
        $display("IF  cyc=%0d pc=%h instr=%h", cyc, exq[0], mem_word(exq[0]));
        void'(exq.pop_front());
      end
      if (kept) exq.push_back(f.addr);
      if (fire) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        pend.push_back('{m_fetch_pc, 1'b1, due});
        last_due   = due;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (rdr) begin
        exq.delete();
        foreach (pend[i]) pend[i].keep = 1'b0;
        m_fetch_pc = {rdr_pc[31:2], 2'b00};
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit          rdr;
    logic [31:0] rpc;

    cyc            = 0;
    last_due       = 0;
    m_fetch_pc     = RESET_PC;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_cycle(1, 0, 0, 1, 1, 1);
    // Streaming with single-cycle memory and a free-running decoder.
    for (int i = 0; i < 30; i++) run_cycle(0, 0, 0, 1, 1, 1);
    // Decoder stalled: queue fills to DEPTH and requests stop, then a single pop.
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1, 0, 1);
    run_cycle(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 1, 1, 1);
    // Memory not ready for five cycles.
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 1, 1, 2);
    // Three fetches in flight at latency 3, then redirect to an unaligned target.
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 1, 0, 3);
    run_cycle(0, 1, 32'h0000_2002, 1, 1, 3);
    for (int i = 0; i < 12; i++) run_cycle(0, 0, 0, 1, 1, 3);
    // Address wrap at the top of the address space.
    run_cycle(0, 1, 32'hFFFF_FFF4, 1, 1, 1);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1, 1, 1);
    // Reset mid-stream.
    run_cycle(1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) run_cycle(0, 0, 0, 1, 1, 1);

    for (int i = 0; i < 1500; i++) begin
      rdr = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      run_cycle($urandom_range(0, 299) == 0, rdr, rpc, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0, $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
